// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: L1 miss handler. On a miss it reads the aligned block from
// the pipelined memory one word per cycle, streams each returning word into
// the cache data array, and writes the tag together with the last word.
// fsm_busy stays high for the whole fill so the pipeline holds.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      miss_detected,
  input  logic [ADDR_WIDTH-1:0]                     miss_address,
  input  logic                                      memory_data_valid,
  input  logic [15:0]                               memory_data,
  output logic                                      mem_enable,
  output logic                                      mem_wr,
  output logic [ADDR_WIDTH-1:0]                     memory_address,
  output logic                                      fsm_busy,
  output logic                                      write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0]            fill_word_index,
  output logic [15:0]                               fill_data,
  output logic                                      write_tag_array,
  output logic [ADDR_WIDTH-$clog2(BLOCK_WORDS)-2:0] fill_tag
);

  // Word index width, and byte-offset width of a block of 16-bit words.
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = IDX_W + 1;

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~((ADDR_WIDTH)'(2 * BLOCK_WORDS - 1));
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;     // block-aligned address; offset bits stay zero
  logic [IDX_W:0]        r_req_cnt;  // requests issued, 0..BLOCK_WORDS
  logic [IDX_W-1:0]      r_rsp_cnt;  // words written so far (wraps after the last)

  logic w_fill;
  logic w_issue;
  logic w_write;
  logic w_last;

  // Fill sequencing: latch the block on a miss, count requests and returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_base    <= miss_address & BLK_MASK;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (!r_req_cnt[IDX_W]) begin
            r_req_cnt <= r_req_cnt + 1'b1;
          end
          if (memory_data_valid) begin
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
            if (r_rsp_cnt == LAST_IDX) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state registers; the data-array write must
  // coincide with the memory's return cycle, so it follows data_valid directly.
  assign w_fill  = (r_state == S_FILL);
  assign w_issue = w_fill && !r_req_cnt[IDX_W];
  assign w_write = w_fill && memory_data_valid;
  assign w_last  = w_write && (r_rsp_cnt == LAST_IDX);

  assign fsm_busy         = w_fill;
  assign mem_enable       = w_issue;
  assign mem_wr           = 1'b0;
  assign memory_address   = w_issue ? (r_base | (ADDR_WIDTH)'({r_req_cnt[IDX_W-1:0], 1'b0}))
                                    : '0;
  assign write_data_array = w_write;
  assign fill_word_index  = r_rsp_cnt;
  assign fill_data        = w_write ? memory_data : '0;
  assign write_tag_array  = w_last;
  assign fill_tag         = r_base[ADDR_WIDTH-1:OFF_W];

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a pipelined memory model with selectable read
// latency feeds the DUT; stimulus pushes expected requests and data-array
// writes into queues and a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  fill_word_index;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [11:0] fill_tag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 4;
  logic force_vld = 1'b0;
  logic mon_en    = 1'b0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .fill_word_index   (fill_word_index),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_tag          (fill_tag)
  );

  // Preloaded memory contents as a function of the byte address.
  function automatic logic [15:0] mfun(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined read memory: {valid, addr} shifts through; output tap = lat.
  logic [16:0] pipe [0:3];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {mem_enable & ~mem_wr, memory_address};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign memory_data_valid = pipe[lat-1][16] | force_vld;
  assign memory_data       = mfun(pipe[lat-1][15:0]);

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } req_t;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        tag;
    logic [11:0] ftag;
  } wr_t;

  req_t req_q[$];
  wr_t  wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"},   32'(fsm_busy), 32'd0);
    chk({name, "_men"},    32'(mem_enable), 32'd0);
    chk({name, "_mwr"},    32'(mem_wr), 32'd0);
    chk({name, "_maddr"},  32'(memory_address), 32'd0);
    chk({name, "_wda"},    32'(write_data_array), 32'd0);
    chk({name, "_idx"},    32'(fill_word_index), 32'd0);
    chk({name, "_fdata"},  32'(fill_data), 32'd0);
    chk({name, "_wtag"},   32'(write_tag_array), 32'd0);
    chk({name, "_ftag"},   32'(fill_tag), 32'd0);
  endtask

  // Monitor: compare every presented request and data write with the queues.
  always @(negedge clk) begin : mon
    req_t r;
    wr_t  w;
    if (mon_en) begin
      chk("mem_wr", 32'(mem_wr), 32'd0);
      if (mem_enable) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'(memory_address), 32'hFFFF_FFFF);
        end else begin
          r = req_q.pop_front();
          chk("req_addr",  32'(memory_address), 32'(r.addr));
          chk("req_cycle", 32'(cyc), 32'(r.cyc));
        end
      end else begin
        chk("idle_addr", 32'(memory_address), 32'd0);
      end
      if (write_data_array) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'(fill_word_index), 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
          chk("wr_idx",   32'(fill_word_index), 32'(w.idx));
          chk("wr_data",  32'(fill_data), 32'(w.data));
          chk("wr_tag",   32'(write_tag_array), 32'(w.tag));
          chk("wr_ftag",  32'(fill_tag), 32'(w.ftag));
        end
      end else begin
        chk("tag_without_write", 32'(write_tag_array), 32'd0);
      end
    end
  end

  // Issue a miss at the current negedge and run the fill until busy drops.
  // With hold=1 miss_detected stays high and the address moves to alt.
  task automatic do_fill(input logic [15:0] addr, input bit hold, input logic [15:0] alt);
    logic [15:0] b;
    int c0;
    int n;
    req_t r;
    wr_t  w;
    b = addr & 16'hFFF0;
    miss_detected = 1'b1;
    miss_address  = addr;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      r.cyc  = c0 + k;
      r.addr = b + 16'(2 * k);
      req_q.push_back(r);
      w.cyc  = c0 + lat + k;
      w.idx  = 3'(k);
      w.data = mfun(b + 16'(2 * k));
      w.tag  = (k == 7);
      w.ftag = b[15:4];
      wr_q.push_back(w);
    end
    if (hold) begin
      miss_address = alt;
    end else begin
      miss_detected = 1'b0;
      miss_address  = 16'($urandom);
    end
    n = 0;
    @(negedge clk);
    while (fsm_busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(8 + lat));
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("wr_q_empty",  32'(wr_q.size()), 32'd0);
    req_q.delete();
    wr_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    req_t r;
    wr_t  w;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: basic fill, 4-cycle memory, unaligned miss address
    lat = 4;
    do_fill(16'h1236, 1'b0, 16'h0);

    // 2: back-to-back misses, second raised the cycle busy falls
    do_fill(16'h0040, 1'b0, 16'h0);
    do_fill(16'hFFF0, 1'b0, 16'h0);

    // 3: miss held high with the address changing mid-fill
    do_fill(16'h2468, 1'b1, 16'h8000);
    do_fill(16'h8000, 1'b0, 16'h0);

    // 4: reset after three data writes abandons the fill
    miss_detected = 1'b1;
    miss_address  = 16'h4ABC;
    @(posedge clk);
    #1;
    c0 = cyc;
    miss_detected = 1'b0;
    for (int k = 0; k < 7; k++) begin
      r.cyc  = c0 + k;
      r.addr = 16'h4AB0 + 16'(2 * k);
      req_q.push_back(r);
    end
    for (int k = 0; k < 3; k++) begin
      w.cyc  = c0 + 4 + k;
      w.idx  = 3'(k);
      w.data = mfun(16'h4AB0 + 16'(2 * k));
      w.tag  = 1'b0;
      w.ftag = 12'h4AB;
      wr_q.push_back(w);
    end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midfill_reset");
    chk("abort_req_q", 32'(req_q.size()), 32'd0);
    chk("abort_wr_q",  32'(wr_q.size()), 32'd0);
    rst = 1'b0;
    do_fill(16'h0100, 1'b0, 16'h0);

    // 5: stray data_valid while idle must be ignored
    @(posedge clk);
    #1;
    force_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_vld_wda",  32'(write_data_array), 32'd0);
      chk("idle_vld_busy", 32'(fsm_busy), 32'd0);
      @(posedge clk);
      #1;
    end
    force_vld = 1'b0;
    @(negedge clk);
    do_fill(16'h0A5E, 1'b0, 16'h0);

    // 6: 1-cycle memory latency
    lat = 1;
    do_fill(16'h7772, 1'b0, 16'h0);
    lat = 4;

    repeat (2) @(negedge clk);
    chk("final_busy", 32'(fsm_busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
